// File: rtl/pipe_stage_fifo.sv
// pipe_stage_fifo
//   Elastic pipeline stage: a DEPTH-entry circular buffer behind valid/ready
//   handshakes on both sides. Stalls come from out_ready_i back-pressure.
//   A synchronous flush (or reset) empties the buffer, and the head output
//   falls back to DEFAULT_DATA, for example a NOP encoding.
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   flush_i      drop all stored entries at this edge
//   in_valid_i   upstream word valid
//   in_ready_o   stage can accept a word (depends only on state)
//   in_data_i    upstream word
//   out_valid_o  head word valid
//   out_ready_i  downstream takes the head word this cycle
//   out_data_o   head word, or DEFAULT_DATA when empty
//   count_o      number of stored entries, 0..DEPTH
module pipe_stage_fifo #(
    parameter int unsigned    DW           = 32,
    parameter int unsigned    DEPTH        = 2,
    parameter logic [DW-1:0]  DEFAULT_DATA = {DW{1'b0}}
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [DW-1:0]              in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DW-1:0]              out_data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;

    // Handshake outputs come from registered state only, so there is no
    // combinational path from out_ready_i to in_ready_o.
    assign in_ready_o  = (count_q != FULL);
    assign out_valid_o = (count_q != '0);
    assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : DEFAULT_DATA;
    assign count_o     = count_q;

    assign push = in_valid_i & in_ready_o;
    assign pop  = out_valid_o & out_ready_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            // A flush wins over any handshake in the same cycle.
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage has no reset. While the buffer is empty, the output mux hides
    // any stale or X contents.
    always_ff @(posedge clk) begin
        if (push && !flush_i && !rst) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

`ifndef SYNTHESIS
    a_count_range : assert property (@(posedge clk) count_q <= FULL);
    a_hold_stable : assert property (@(posedge clk)
        (out_valid_o && !out_ready_i && !flush_i && !rst) |=> $stable(out_data_o));
`endif

endmodule

// File: doc/pipe_stage_fifo.md
Name: pipe_stage_fifo

Overview:
- Parametrised elastic pipeline stage that replaces the fixed flush/hold stage registers.
- Buffers up to DEPTH words of DW bits behind a valid/ready handshake on both sides.
- Supports a synchronous flush that drops all entries and drives a programmable default word.
- Sits between any two core pipeline stages (e.g. ID->EX). Stalls come from ready back-pressure, not a separate hold flag.

Parameters:
- DW, 32, payload width in bits (>=1).
- DEPTH, 2, number of buffer entries; power of two, >=2.
- DEFAULT_DATA, {DW{1'b0}}, word driven on out_data_o when the buffer is empty (e.g. NOP encoding).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- flush_i  in  1  synchronous flush; discards all entries.
- in_valid_i  in  1  upstream word valid.
- in_ready_o  out  1  stage can accept a word this cycle.
- in_data_i  in  DW  upstream word.
- out_valid_o  out  1  head word valid.
- out_ready_i  in  1  downstream accepts head word this cycle.
- out_data_o  out  DW  head word, or DEFAULT_DATA when empty.
- count_o  out  $clog2(DEPTH+1)  number of stored entries.

Behaviour:
- Storage: circular buffer with DEPTH entries.
  - Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy counter range is 0..DEPTH.
- Handshake events:
  - push = in_valid_i & in_ready_o.
  - pop = out_valid_o & out_ready_i.
  - A word transfers only on the cycle its valid and ready are both high.
- Output decode (combinational from state only):
  - in_ready_o = (count != DEPTH). It has no combinational dependence on out_ready_i.
  - out_valid_o = (count != 0).
  - out_data_o = mem[rd_ptr] when count != 0, else DEFAULT_DATA.
  - count_o = count.
- Latency:
  - A word pushed in cycle N is visible on out_data_o/out_valid_o in cycle N+1 at the earliest.
  - There is no same-cycle pass-through, including when empty.
- Throughput: one word per cycle sustained when out_ready_i is held high, because DEPTH >= 2.
- Simultaneous push and pop:
  - Permitted when 0 < count < DEPTH. Count is unchanged and both pointers advance.
  - Push while full is impossible because in_ready_o is low.
  - Pop while empty is impossible because out_valid_o is low.
- Ordering: strict FIFO; words leave in push order with no loss or duplication.
- Flush (flush_i=1 at a clock edge):
  - Next state: count=0, rd_ptr=wr_ptr=0.
  - Any push or pop in the same cycle is ignored; the input word is discarded.
  - Following cycle: out_valid_o=0, out_data_o=DEFAULT_DATA, in_ready_o=1.
  - Memory contents need not be cleared.
- Reset priority: rst > flush_i > push/pop.
  - Reset has the same effect as flush. It may be asserted mid-transfer; all in-flight entries are lost.
- Reset values:
  - in_ready_o=1, out_valid_o=0, out_data_o=DEFAULT_DATA, count_o=0.
- Input checking: in_data_i is ignored when in_valid_i=0. No X may propagate to out_data_o while empty.
- Assertions (sim only):
  - count <= DEPTH.
  - out_valid_o=1 with out_ready_i=0 implies out_data_o is stable next cycle, unless flush or reset intervenes.

Test Plan (DW=8, DEPTH=4, DEFAULT_DATA=8'h13):
- Reset then idle -> out_valid_o=0, out_data_o=8'h13, in_ready_o=1, count_o=0.
- Push 8'hA1,A2,A3,A4 on consecutive cycles with out_ready_i=0:
  - count_o steps 1,2,3,4; in_ready_o=0 after the 4th push.
  - out_data_o=8'hA1 from the cycle after the first push.
- Drain the full buffer with out_ready_i=1 -> pops A1,A2,A3,A4 in order, one per cycle; out_valid_o=0 and out_data_o=8'h13 after the last pop.
- Streaming: in_valid_i=1 and out_ready_i=1 for 10 cycles, data 8'h00..8'h09:
  - Output 8'h00..8'h09 with 1-cycle latency and no bubbles.
  - count_o stays at 1; pointers wrap past 3 cleanly.
- Flush with 3 entries stored and in_valid_i=1 on the same cycle (data 8'hFF):
  - Next cycle count_o=0, out_valid_o=0, out_data_o=8'h13.
  - 8'hFF is never output.
- rst and flush_i asserted together mid-stream, then push 8'h55 -> reset state first; 8'h55 appears alone with count_o=1.
